cc_cond_unit: RTL and testbench

//   Execute-stage consumer of the 64-bit ALU result. Derives ZF/SF from alu_out, takes OF from the ALU,
//   and holds them in the architectural condition-code (CC) register. Evaluates the jXX/cmovXX

---
 rtl/y86_pkg.sv | 42 ++++
 rtl/cc_cond_unit_cond_eval.sv | 40 ++++
 rtl/cc_cond_unit.sv | 95 +++++++++
 tb/tb_cc_cond_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
//   Shared Y86-64 pipeline definitions: instruction codes, jXX/cmovXX
//   condition codes, stage status codes, the condition-code register layout
//   and its reset value.
// ---------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes (icode field)
    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;

    // Condition codes (ifun field of jXX / cmovXX)
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Stage status codes
    typedef enum logic [1:0] {
        AOK = 2'b00,
        HLT = 2'b01,
        ADR = 2'b10,
        INS = 2'b11
    } stat_t;

    // Architectural condition-code register, packed as {ZF,SF,OF}
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
//   Purely combinational evaluation of a jXX/cmovXX condition against a set
//   of condition flags. Shared with the branch-prediction checker.
//   Ports:
//     ifun  in  4  condition code (C_YES .. C_G; 7..15 never taken)
//     zf    in  1  zero flag
//     sf    in  1  sign flag
//     of    in  1  overflow flag
//     cnd   out 1  condition result
// ---------------------------------------------------------------------------
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    // Signed "less than" after a compare is SF xor OF
    logic lt;
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_cond_unit.sv
// ---------------------------------------------------------------------------
// cc_cond_unit
//   Execute-stage consumer of the ALU result. Derives ZF/SF from alu_out,
//   takes OF from the ALU and holds them in the architectural condition-code
//   register. Evaluates the jXX/cmovXX condition from the registered flags
//   and pipelines it into the E->M register as M_cnd.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     E_icode, E_ifun    instruction in Execute
//     E_valid            Execute holds a real instruction (not a bubble)
//     alu_out, alu_of    ALU result and signed overflow
//     m_stat, W_stat     status of the instructions in Memory / Writeback
//     M_stall, M_bubble  E->M register control (bubble wins over stall)
//     cc_zf/cc_sf/cc_of  registered condition flags
//     e_cnd              condition from the registered flags and E_ifun
//     set_cc             flags update at the next edge
//     M_cnd              registered e_cnd
// ---------------------------------------------------------------------------
module cc_cond_unit #(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = y86_pkg::CC_RESET
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic             E_valid,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_of,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    input  logic             M_stall,
    input  logic             M_bubble,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic             e_cnd,
    output logic             set_cc,
    output logic             M_cnd
);

    import y86_pkg::*;

    cc_t  cc_d, cc_q;
    logic m_cnd_d, m_cnd_q;

    // A faulting instruction ahead in M or W must not see its successor
    // modify the flags, so the write is squashed while either is not AOK.
    assign set_cc = E_valid & (E_icode == OPQ) &
                    (m_stat == AOK) & (W_stat == AOK);

    always_comb begin
        cc_d = cc_q;
        if (set_cc) begin
            cc_d.zf = (alu_out == '0);
            cc_d.sf = alu_out[WIDTH-1];
            cc_d.of = alu_of;
        end
    end

    // The condition deliberately looks at the registered flags only; an OPq
    // directly ahead of a jXX is seen one cycle later.
    cond_eval u_cond_eval (
        .ifun (E_ifun),
        .zf   (cc_q.zf),
        .sf   (cc_q.sf),
        .of   (cc_q.of),
        .cnd  (e_cnd)
    );

    always_comb begin
        m_cnd_d = e_cnd;
        if (M_bubble) begin
            m_cnd_d = 1'b0;
        end else if (M_stall) begin
            m_cnd_d = m_cnd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q    <= CC_RESET;
            m_cnd_q <= 1'b0;
        end else begin
            cc_q    <= cc_d;
            m_cnd_q <= m_cnd_d;
        end
    end

    assign cc_zf = cc_q.zf;
    assign cc_sf = cc_q.sf;
    assign cc_of = cc_q.of;
    assign M_cnd = m_cnd_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
module tb_cc_cond_unit;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  E_icode, E_ifun;
    logic        E_valid;
    logic [63:0] alu_out;
    logic        alu_of;
    logic [1:0]  m_stat, W_stat;
    logic        M_stall, M_bubble;
    logic        cc_zf, cc_sf, cc_of, e_cnd, set_cc, M_cnd;

    // Standalone evaluator, used to reach flag combinations (ZF=1,SF=1)
    // that no ALU result can load into the register.
    logic [3:0]  ce_ifun;
    logic        ce_zf, ce_sf, ce_of, ce_cnd;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cc_cond_unit #(.WIDTH(64), .CC_RESET(3'b100)) dut (
        .clk(clk), .rst_n(rst_n), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valid(E_valid), .alu_out(alu_out), .alu_of(alu_of),
        .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall),
        .M_bubble(M_bubble), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
        .e_cnd(e_cnd), .set_cc(set_cc), .M_cnd(M_cnd)
    );

    cond_eval u_ce (
        .ifun(ce_ifun), .zf(ce_zf), .sf(ce_sf), .of(ce_of), .cnd(ce_cnd)
    );

    // Condition table written out from the instruction-set definition
    function automatic logic exp_cnd(input int ifun, input logic zf,
                                     input logic sf, input logic of);
        if (ifun == 0) return 1'b1;
        if (ifun == 1) return (sf != of) || zf;
        if (ifun == 2) return (sf != of);
        if (ifun == 3) return zf;
        if (ifun == 4) return !zf;
        if (ifun == 5) return (sf == of);
        if (ifun == 6) return (sf == of) && !zf;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads the flags through a normal OPq write (only ZF&SF=1 unreachable)
    task automatic load_cc(input logic zf, input logic sf, input logic of);
        E_valid = 1'b1; E_icode = OPQ; m_stat = AOK; W_stat = AOK;
        alu_out = zf ? 64'h0 : (sf ? 64'h8000_0000_0000_0000 : 64'h1);
        alu_of  = of;
        step();
        E_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; M_stall = 1'b0; M_bubble = 1'b0;
        E_valid = 1'b1; E_icode = OPQ; E_ifun = C_NE;
        alu_out = 64'hFFFF_FFFF_FFFF_FFFE; alu_of = 1'b0;
        m_stat = AOK; W_stat = AOK;
        step();
        step();
        // Here CC=010 and M_cnd=1; assert reset between edges
        E_ifun = C_E;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_cc: got %b expected 100", {cc_zf, cc_sf, cc_of});
        end
        n_vec++;
        if (M_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mcnd: got %b expected 0", M_cnd);
        end
        n_vec++;
        if (e_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ecnd_e: got %b expected 1", e_cnd);
        end
        // Held reset discards the pending OPq update across an edge
        step();
        n_vec++;
        if ({cc_zf, cc_sf, cc_of, M_cnd} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_hold: got %b expected 1000", {cc_zf, cc_sf, cc_of, M_cnd});
        end
        E_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_opq();
        E_valid = 1'b1; E_icode = OPQ; E_ifun = 4'h0;
        alu_out = 64'hFFFF_FFFF_FFFF_FFFE; alu_of = 1'b0;
        m_stat = AOK; W_stat = AOK;
        #1;
        n_vec++;
        if (set_cc !== 1'b1) begin
            n_bad++;
            $display("FAIL opq_set_cc: got %b expected 1", set_cc);
        end
        n_vec++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            n_bad++;
            $display("FAIL opq_before_edge: got %b expected 100", {cc_zf, cc_sf, cc_of});
        end
        step();
        E_valid = 1'b0;
        n_vec++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin
            n_bad++;
            $display("FAIL opq_flags: got %b expected 010", {cc_zf, cc_sf, cc_of});
        end
        E_ifun = C_L;
        #1;
        n_vec++;
        if (e_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL opq_l: got %b expected 1", e_cnd);
        end
        E_ifun = C_G;
        #1;
        n_vec++;
        if (e_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL opq_g: got %b expected 0", e_cnd);
        end
    endtask

    task automatic test_exception();
        // CC is 010 on entry
        E_valid = 1'b1; E_icode = OPQ; alu_out = 64'h0; alu_of = 1'b1;
        m_stat = ADR; W_stat = AOK;
        #1;
        n_vec++;
        if (set_cc !== 1'b0) begin
            n_bad++;
            $display("FAIL exc_m_set_cc: got %b expected 0", set_cc);
        end
        step();
        n_vec++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin
            n_bad++;
            $display("FAIL exc_m_cc: got %b expected 010", {cc_zf, cc_sf, cc_of});
        end
        m_stat = AOK; W_stat = INS;
        #1;
        n_vec++;
        if (set_cc !== 1'b0) begin
            n_bad++;
            $display("FAIL exc_w_set_cc: got %b expected 0", set_cc);
        end
        step();
        n_vec++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin
            n_bad++;
            $display("FAIL exc_w_cc: got %b expected 010", {cc_zf, cc_sf, cc_of});
        end
        // Both stages clear: the same ALU result now lands
        W_stat = AOK;
        step();
        n_vec++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b101) begin
            n_bad++;
            $display("FAIL exc_clear_cc: got %b expected 101", {cc_zf, cc_sf, cc_of});
        end
        E_valid = 1'b0;
    endtask

    task automatic test_non_opq();
        load_cc(1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
            n_bad++;
            $display("FAIL nonop_setup: got %b expected 000", {cc_zf, cc_sf, cc_of});
        end
        E_valid = 1'b1; E_icode = JXX; alu_out = 64'h0; alu_of = 1'b1;
        #1;
        n_vec++;
        if (set_cc !== 1'b0) begin
            n_bad++;
            $display("FAIL nonop_jxx_set_cc: got %b expected 0", set_cc);
        end
        step();
        n_vec++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
            n_bad++;
            $display("FAIL nonop_jxx_cc: got %b expected 000", {cc_zf, cc_sf, cc_of});
        end
        E_valid = 1'b0; E_icode = OPQ;
        step();
        n_vec++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
            n_bad++;
            $display("FAIL nonop_bubble_cc: got %b expected 000", {cc_zf, cc_sf, cc_of});
        end
    endtask

    task automatic test_sweep();
        logic [2:0] combos [6];
        logic       ex;
        combos = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        for (int c = 0; c < 6; c++) begin
            load_cc(combos[c][2], combos[c][1], combos[c][0]);
            for (int f = 0; f < 16; f++) begin
                E_ifun = f[3:0];
                #1;
                ex = exp_cnd(f, combos[c][2], combos[c][1], combos[c][0]);
                n_vec++;
                if (e_cnd !== ex) begin
                    n_bad++;
                    $display("FAIL sweep_top cc=%b ifun=%0d: got %b expected %b",
                             combos[c], f, e_cnd, ex);
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            {ce_zf, ce_sf, ce_of} = c[2:0];
            for (int f = 0; f < 16; f++) begin
                ce_ifun = f[3:0];
                #1;
                ex = exp_cnd(f, ce_zf, ce_sf, ce_of);
                n_vec++;
                if (ce_cnd !== ex) begin
                    n_bad++;
                    $display("FAIL sweep_eval cc=%b ifun=%0d: got %b expected %b",
                             c[2:0], f, ce_cnd, ex);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        // OPq then immediate jXX: e_cnd reflects new flags only after the edge
        load_cc(1'b0, 1'b0, 1'b0);
        E_valid = 1'b1; E_icode = OPQ; alu_out = 64'h0; alu_of = 1'b0;
        E_ifun = C_E;
        #1;
        n_vec++;
        if (e_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_before: got %b expected 0", e_cnd);
        end
        step();
        E_icode = JXX;
        #1;
        n_vec++;
        if (e_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_after: got %b expected 1", e_cnd);
        end
        E_valid = 1'b0;
    endtask

    task automatic test_mcnd();
        load_cc(1'b0, 1'b0, 1'b0);
        E_ifun = C_NE;                      // e_cnd = 1
        M_bubble = 1'b1; M_stall = 1'b0;
        step();
        n_vec++;
        if (M_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL mcnd_bubble: got %b expected 0", M_cnd);
        end
        M_bubble = 1'b0; M_stall = 1'b1;
        step();
        n_vec++;
        if (M_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL mcnd_stall_hold0: got %b expected 0", M_cnd);
        end
        M_bubble = 1'b1;
        step();
        n_vec++;
        if (M_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL mcnd_both0: got %b expected 0", M_cnd);
        end
        M_bubble = 1'b0; M_stall = 1'b0;
        step();
        n_vec++;
        if (M_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL mcnd_release: got %b expected 1", M_cnd);
        end
        E_ifun = C_E;                       // e_cnd = 0
        M_stall = 1'b1;
        step();
        n_vec++;
        if (M_cnd !== 1'b1) begin
            n_bad++;
            $display("FAIL mcnd_stall_hold1: got %b expected 1", M_cnd);
        end
        E_ifun = C_NE;
        M_bubble = 1'b1;
        step();
        n_vec++;
        if (M_cnd !== 1'b0) begin
            n_bad++;
            $display("FAIL mcnd_both_from1: got %b expected 0", M_cnd);
        end
        n_vec++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
            n_bad++;
            $display("FAIL mcnd_cc_untouched: got %b expected 000", {cc_zf, cc_sf, cc_of});
        end
        M_bubble = 1'b0; M_stall = 1'b0;
    endtask

    initial begin
        ce_ifun = 4'h0; ce_zf = 1'b0; ce_sf = 1'b0; ce_of = 1'b0;
        test_reset();
        test_opq();
        test_exception();
        test_non_opq();
        test_sweep();
        test_back_to_back();
        test_mcnd();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
